// File: rtl/mii_tx_mac.sv
// MII transmit MAC: frames FIFO bytes as preamble, SFD, data, pad and CRC-32 FCS
// onto a 4-bit PHY interface, then holds the inter-frame gap.
//
// state | meaning
// IDLE  | line quiet, waiting for tx_mac_valid
// PRE   | preamble nibbles 0x5
// SFD   | 0x5 then 0xD; first byte accepted in the 0xD cycle
// DATA  | registered byte out, low nibble then high nibble
// PAD   | zero bytes up to the minimum frame size
// FCS   | inverted CRC nibbles, LSB nibble first
// ABORT | underrun: TX_ER asserted for one byte time
// IFG   | TX_EN low for the inter-frame gap
module mii_tx_mac #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int MIN_FRAME      = 60,
    parameter int IFG_BYTES      = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_mac_data,
    input  logic       tx_mac_valid,
    input  logic       tx_mac_last,
    output logic       tx_mac_ready,
    output logic       phy_tx_en,
    output logic [3:0] phy_txd,
    output logic       phy_tx_err,
    output logic       tx_done,
    output logic       tx_underrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_ABORT, S_IFG
    } state_t;

    localparam logic [7:0]  PRE_LOAD = 8'(2 * PREAMBLE_BYTES - 1);
    localparam logic [7:0]  IFG_LOAD = 8'(2 * IFG_BYTES - 1);
    localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic        last_q, last_d;
    logic [10:0] byte_cnt_q, byte_cnt_d, byte_cnt_inc;
    logic [31:0] crc_q, crc_d;
    logic        tx_en_q, tx_en_d;
    logic [3:0]  txd_q, txd_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        underrun_q, underrun_d;
    logic        go_pre, load_byte, go_pad, go_fcs, go_abort, go_ifg;

    // Reflected CRC-32, one nibble, LSB first.
    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 4; i++) begin
            r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? 32'hEDB8_8320 : 32'h0);
        end
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        byte_d       = byte_q;
        last_d       = last_q;
        byte_cnt_d   = byte_cnt_q;
        crc_d        = crc_q;
        tx_en_d      = 1'b0;
        txd_d        = 4'h0;
        err_d        = 1'b0;
        ready_d      = 1'b0;
        done_d       = 1'b0;
        underrun_d   = 1'b0;
        go_pre       = 1'b0;
        load_byte    = 1'b0;
        go_pad       = 1'b0;
        go_fcs       = 1'b0;
        go_abort     = 1'b0;
        go_ifg       = 1'b0;
        byte_cnt_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;

        unique case (state_q)
            S_IDLE: go_pre = tx_mac_valid;
            S_PRE: begin
                tx_en_d = 1'b1;
                txd_d   = 4'h5;
                if (cnt_q == 8'd0) begin
                    state_d = S_SFD;
                    phase_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_SFD: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    tx_en_d = 1'b1;
                    txd_d   = 4'hD;
                    ready_d = 1'b1;
                end else if (tx_mac_valid) begin
                    load_byte = 1'b1;
                end else begin
                    go_abort = 1'b1;
                end
            end
            S_DATA: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    tx_en_d = 1'b1;
                    txd_d   = byte_q[7:4];
                    crc_d   = crc_nib(crc_q, byte_q[7:4]);
                    ready_d = !last_q;
                end else if (!last_q) begin
                    load_byte = tx_mac_valid;
                    go_abort  = !tx_mac_valid;
                end else if (byte_cnt_q < MIN_CNT) begin
                    go_pad = 1'b1;
                end else begin
                    go_fcs = 1'b1;
                end
            end
            S_PAD: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    tx_en_d = 1'b1;
                    crc_d   = crc_nib(crc_q, 4'h0);
                end else if (byte_cnt_q < MIN_CNT) begin
                    go_pad = 1'b1;
                end else begin
                    go_fcs = 1'b1;
                end
            end
            S_FCS: begin
                if (cnt_q == 8'd0) begin
                    go_ifg = 1'b1;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                    tx_en_d = 1'b1;
                    txd_d   = ~crc_q[3:0];
                    crc_d   = crc_q >> 4;
                    done_d  = (cnt_q == 8'd1);
                end
            end
            S_ABORT: begin
                if (cnt_q == 8'd0) begin
                    go_ifg = 1'b1;
                end else begin
                    cnt_d   = 8'd0;
                    tx_en_d = 1'b1;
                    err_d   = 1'b1;
                end
            end
            S_IFG: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (tx_mac_valid) begin
                    go_pre = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        if (go_pre) begin
            state_d    = S_PRE;
            cnt_d      = PRE_LOAD;
            crc_d      = 32'hFFFF_FFFF;
            byte_cnt_d = 11'd0;
            tx_en_d    = 1'b1;
            txd_d      = 4'h5;
        end
        if (load_byte) begin
            state_d    = S_DATA;
            phase_d    = 1'b0;
            byte_d     = tx_mac_data;
            last_d     = tx_mac_last;
            byte_cnt_d = byte_cnt_inc;
            tx_en_d    = 1'b1;
            txd_d      = tx_mac_data[3:0];
            crc_d      = crc_nib(crc_q, tx_mac_data[3:0]);
        end
        if (go_pad) begin
            state_d    = S_PAD;
            phase_d    = 1'b0;
            byte_cnt_d = byte_cnt_inc;
            tx_en_d    = 1'b1;
            txd_d      = 4'h0;
            crc_d      = crc_nib(crc_q, 4'h0);
        end
        // crc_q already holds the final remainder here; shift it out nibble by nibble.
        if (go_fcs) begin
            state_d = S_FCS;
            cnt_d   = 8'd7;
            tx_en_d = 1'b1;
            txd_d   = ~crc_q[3:0];
            crc_d   = crc_q >> 4;
        end
        if (go_abort) begin
            state_d    = S_ABORT;
            cnt_d      = 8'd1;
            tx_en_d    = 1'b1;
            err_d      = 1'b1;
            underrun_d = 1'b1;
        end
        if (go_ifg) begin
            state_d = S_IFG;
            cnt_d   = IFG_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            phase_q    <= 1'b0;
            cnt_q      <= 8'd0;
            byte_q     <= 8'd0;
            last_q     <= 1'b0;
            byte_cnt_q <= 11'd0;
            crc_q      <= 32'd0;
            tx_en_q    <= 1'b0;
            txd_q      <= 4'h0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            last_q     <= last_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            tx_en_q    <= tx_en_d;
            txd_q      <= txd_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign tx_mac_ready = ready_q;
    assign phy_tx_en    = tx_en_q;
    assign phy_txd      = txd_q;
    assign phy_tx_err   = err_q;
    assign tx_done      = done_q;
    assign tx_underrun  = underrun_q;

endmodule

// File: tb/tb_mii_tx_mac.sv
// Scoreboard bench for mii_tx_mac: expected nibble streams are queued when a
// frame is driven and compared cycle by cycle as the PHY side emits them.
module tb_mii_tx_mac;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_mac_data;
    logic       tx_mac_valid;
    logic       tx_mac_last;
    logic       tx_mac_ready;
    logic       phy_tx_en;
    logic [3:0] phy_txd;
    logic       phy_tx_err;
    logic       tx_done;
    logic       tx_underrun;

    mii_tx_mac dut (
        .clk          (clk),
        .reset        (reset),
        .tx_mac_data  (tx_mac_data),
        .tx_mac_valid (tx_mac_valid),
        .tx_mac_last  (tx_mac_last),
        .tx_mac_ready (tx_mac_ready),
        .phy_tx_en    (phy_tx_en),
        .phy_txd      (phy_txd),
        .phy_tx_err   (phy_tx_err),
        .tx_done      (tx_done),
        .tx_underrun  (tx_underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int rmax;
        int gap;
    } meta_t;

    meta_t      meta_q[$];
    logic [6:0] exp_q[$];
    logic [7:0] fb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         rst_drop = 1'b0;
    bit         in_frame = 1'b0;
    int         k = 0;
    int         gap_cnt = 0;
    meta_t      cur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    // mode: 0 normal, 1 underrun after cut bytes, 2 reset after cut bytes
    task automatic send_frame(input int len, input int mode, input int cut, input int gap,
                              input bit chk_lat, input bit rnd, input logic [7:0] base);
        logic [31:0] crc;
        logic [31:0] fcs;
        meta_t       m;
        int          nd, nx, i, cyc;
        fb.delete();
        for (int j = 0; j < len; j++) fb.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(base + j));
        for (int j = 0; j < 15; j++) exp_q.push_back(7'h05);
        exp_q.push_back(7'h0D);
        if (mode == 1) begin
            for (int j = 0; j < cut; j++) begin
                exp_q.push_back({3'b000, fb[j][3:0]});
                exp_q.push_back({3'b000, fb[j][7:4]});
            end
            exp_q.push_back(7'b011_0000);
            exp_q.push_back(7'b001_0000);
            m.len  = 16 + 2 * cut + 2;
            m.rmax = 16 + 2 * cut - 1;
        end else begin
            nd  = (len < 60) ? 60 : len;
            crc = 32'hFFFF_FFFF;
            for (int j = 0; j < nd; j++) begin
                logic [7:0] b;
                b   = (j < len) ? fb[j] : 8'h00;
                crc = crc_byte(crc, b);
                exp_q.push_back({3'b000, b[3:0]});
                exp_q.push_back({3'b000, b[7:4]});
            end
            fcs = ~crc;
            for (int j = 0; j < 8; j++) exp_q.push_back({(j == 7), 2'b00, fcs[4*j +: 4]});
            m.len  = 16 + 2 * nd + 8;
            m.rmax = 16 + 2 * len - 3;
        end
        m.gap = gap;
        meta_q.push_back(m);

        nx  = (mode == 0) ? len : cut;
        i   = 0;
        cyc = 0;
        while (i < nx && cyc < 3000) begin
            @(negedge clk);
            tx_mac_valid = 1'b1;
            tx_mac_data  = fb[i];
            tx_mac_last  = (i == len - 1);
            if (chk_lat && cyc == 0) chk("latency_pre", phy_tx_en, 0);
            if (chk_lat && cyc == 1) chk("latency", phy_tx_en, 1);
            if (tx_mac_ready) i++;
            cyc++;
        end
        chk("drive_count", i, nx);
        if (mode == 1) begin
            cyc = 0;
            @(negedge clk);
            tx_mac_valid = 1'b0;
            tx_mac_last  = 1'b0;
            while (!tx_mac_ready && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            chk("underrun_ready", tx_mac_ready, 1);
        end else if (mode == 2) begin
            @(negedge clk);
            reset        = 1'b1;
            tx_mac_valid = 1'b0;
            tx_mac_last  = 1'b0;
            rst_drop     = 1'b1;
            @(negedge clk);
            chk("reset_out", {phy_tx_en, phy_txd, phy_tx_err, tx_done, tx_underrun, tx_mac_ready}, 0);
            reset = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            tx_mac_valid = 1'b0;
            tx_mac_last  = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (phy_tx_en) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                k = 0;
                chk("frame_expected", (meta_q.size() > 0), 1);
                if (meta_q.size() > 0) cur = meta_q.pop_front();
                else begin
                    cur.len = 0;
                    cur.rmax = 0;
                    cur.gap = 0;
                end
                if (cur.gap != 0) chk("ifg", gap_cnt, cur.gap);
            end
            if (k < cur.len && exp_q.size() > 0)
                chk("nibble", {tx_done, tx_underrun, phy_tx_err, phy_txd}, exp_q.pop_front());
            else
                chk("frame_len_over", k + 1, cur.len);
            chk("ready", tx_mac_ready, (k == 15) || (k >= 17 && (k % 2) == 1 && k <= cur.rmax));
            k++;
        end else begin
            if (in_frame) begin
                in_frame = 1'b0;
                if (!rst_drop) chk("frame_len", k, cur.len);
                rst_drop = 1'b0;
                while (k < cur.len && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    k++;
                end
                gap_cnt = 0;
            end
            gap_cnt++;
            chk("idle_out", {tx_mac_ready, tx_done, tx_underrun, phy_tx_err, phy_txd}, 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset        = 1'b1;
        tx_mac_valid = 1'b0;
        tx_mac_last  = 1'b0;
        tx_mac_data  = 8'h00;
        repeat (4) @(negedge clk);
        chk("reset_state", {phy_tx_en, phy_txd, phy_tx_err, tx_done, tx_underrun, tx_mac_ready}, 0);
        reset = 1'b0;

        send_frame(64, 0, 0, 0, 1'b1, 1'b0, 8'h00);   // 0x00..0x3F
        send_frame(1, 0, 0, 24, 1'b0, 1'b0, 8'hA5);   // padded, back-to-back
        send_frame(70, 0, 0, 24, 1'b0, 1'b1, 8'h00);
        send_frame(20, 1, 10, 24, 1'b0, 1'b1, 8'h00); // underrun after 10 bytes
        send_frame(60, 0, 0, 24, 1'b0, 1'b1, 8'h00);  // exactly minimum size
        idle(60);
        send_frame(30, 2, 12, 0, 1'b0, 1'b1, 8'h00);  // reset in DATA
        send_frame(59, 0, 0, 0, 1'b1, 1'b1, 8'h00);
        send_frame(61, 0, 0, 24, 1'b0, 1'b1, 8'h00);
        idle(1);

        cyc = 0;
        while ((meta_q.size() != 0 || in_frame) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        chk("drain", meta_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
